// File: rtl/ingress_bundle_arb.sv
// ingress_bundle_arb: bundle-atomic round-robin arbiter feeding the order-book ingress.
// Optional PIPEBOMB_ARB_NOP_DROP_EN consumes mid-bundle ITCH_NOP beats without forwarding them.
package pipebomb_pkg;
  localparam logic [3:0] ITCH_NOP = 4'h0;
  localparam logic [3:0] ITCH_ADD = 4'h1;
  typedef struct packed {
    logic [3:0]  opcode;
    logic        last_in_bundle;
    logic [15:0] data;
  } inst_t;
endpackage

module ingress_bundle_arb import pipebomb_pkg::*; #(
  parameter int N_SRC = 2,
  parameter int MAX_BUNDLE = 16,
  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    src_v,
  output logic [N_SRC-1:0]    src_r,
  input  inst_t [N_SRC-1:0]   src_d,
  output logic                m_v,
  input  logic                m_r,
  output inst_t               m_d,
  output logic [GW-1:0]       grant_idx,
  output logic                locked,
  output logic                bundle_abort,
  output logic [31:0]         stat_bundles,
  output logic [15:0]         stat_aborts
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;
  logic [0:0] state;
  logic [GW-1:0] rr_ptr, sel, nxt;
  logic [7:0] beat_cnt;
  logic can_acc, xfer, last, force_close, drop;
  inst_t beat, fwd;
  assign can_acc = !m_v || m_r;
  assign locked = state == S_LOCKED;
  // wrap-around pick first, then any valid source at or above rr_ptr overrides it
  always_comb begin
    sel = rr_ptr;
    for (int i = N_SRC - 1; i >= 0; i--) if (src_v[i]) sel = GW'(i);
    for (int i = N_SRC - 1; i >= 0; i--) if (src_v[i] && GW'(i) >= rr_ptr) sel = GW'(i);
    if (locked) sel = grant_idx;
  end
  always_comb begin
    beat = '0;
    src_r = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (GW'(i) == sel) beat = src_d[i];
      src_r[i] = can_acc && (locked || |src_v) && GW'(i) == sel;
    end
  end
  assign xfer = |(src_v & src_r);
  assign last = beat.last_in_bundle;
  assign force_close = locked && !last && beat_cnt == 8'(MAX_BUNDLE - 1);
  assign nxt = (sel == GW'(N_SRC - 1)) ? '0 : sel + GW'(1);
  always_comb begin
    fwd = beat;
    fwd.last_in_bundle = last || force_close;
  end
`ifdef PIPEBOMB_ARB_NOP_DROP_EN
  assign drop = beat.opcode == ITCH_NOP && !fwd.last_in_bundle;
`else
  assign drop = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rr_ptr <= '0;
      grant_idx <= '0;
      beat_cnt <= '0;
      m_v <= 1'b0;
      m_d <= '0;
      bundle_abort <= 1'b0;
      stat_bundles <= '0;
      stat_aborts <= '0;
    end else begin
      bundle_abort <= xfer && force_close;
      if (can_acc) m_v <= xfer && !drop;
      if (xfer && !drop) m_d <= fwd;
      if (xfer) begin
        if (last || force_close) begin
          state <= S_IDLE;
          rr_ptr <= nxt;
        end else if (!locked) begin
          state <= S_LOCKED;
          grant_idx <= sel;
          beat_cnt <= 8'd1;
        end else beat_cnt <= beat_cnt + 8'd1;
        if (last) stat_bundles <= stat_bundles + 32'd1;
        if (force_close && stat_aborts != 16'hFFFF) stat_aborts <= stat_aborts + 16'd1;
      end
    end
  end
endmodule
